mmu_ptw_arbiter: RTL and testbench
==================================

# mmu_ptw_arbiter

Shares the MMU's single page-table walker between the instruction TLB and data TLB miss paths in the sv39/H-capable CVA6 MMU. It accepts one miss at a time, forwards it to the PTW, and routes the walk completion back to the originator. DTLB misses have priority, and a starvation counter guarantees ITLB progress. It also handles flush (sfence.vma/hfence) aborts of queued or in-flight walks.

## Interface
- `VPN_W`, 27: virtual page number width (sv39: 3×9).
- `HYP_EXT`, 0: 1 enables guest-translation (`*_v_*`) forwarding; when 0, `ptw_req_v_o` is tied 0.
- `STARVE_LIMIT`, 4: consecutive DTLB grants allowed while ITLB waits; range 1..15.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: abort pending/in-flight walk.
- `itlb_req_valid_i` in 1, `itlb_req_vpn_i` in VPN_W, `itlb_req_v_i` in 1: ITLB miss request.
- `itlb_req_ready_o` out 1: ITLB request accepted this cycle.
- `dtlb_req_valid_i` in 1, `dtlb_req_vpn_i` in VPN_W, `dtlb_req_v_i` in 1, `dtlb_req_is_store_i` in 1: DTLB miss request.
- `dtlb_req_ready_o` out 1: DTLB request accepted this cycle.
- `itlb_resp_valid_o` / `dtlb_resp_valid_o` out 1: walk done, one-cycle pulse.
- `itlb_resp_err_o` / `dtlb_resp_err_o` out 1: walk faulted; qualified by the matching valid.
- `ptw_req_valid_o` out 1, `ptw_req_ready_i` in 1: PTW request handshake.
- `ptw_req_vpn_o` out VPN_W, `ptw_req_is_instr_o` out 1, `ptw_req_is_store_o` out 1, `ptw_req_v_o` out 1: request payload.
- `ptw_resp_valid_i` in 1, `ptw_resp_err_i` in 1: walk completion from the PTW.
- `busy_o` out 1: FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: grant if any valid and `!flush_i`; latch vpn/v/store/source into the payload register, then go to REQ.
  - REQ: `ptw_req_valid_o`=1 with the latched payload; on `ptw_req_ready_i`, go to WALK.
  - WALK: on `ptw_resp_valid_i`, register the response to the latched source, then go to IDLE.
  - DRAIN: wait for `ptw_resp_valid_i`, discard it, then go to IDLE.
- Grant rule: only DTLB valid → DTLB. Only ITLB valid → ITLB. Both valid → DTLB, unless `starve_cnt == STARVE_LIMIT`, then ITLB.
- `*_req_ready_o` is combinational: high only in IDLE, `!flush_i`, and for the granted side. At most one is high per cycle.
- `starve_cnt` (width clog2(STARVE_LIMIT+1)):
  - +1 on a DTLB grant while ITLB valid.
  - Cleared on an ITLB grant, or on a DTLB grant with ITLB not valid.
  - Saturates at STARVE_LIMIT.
  - Cleared by reset only; flush leaves it unchanged.
- Flush:
  - IDLE: block acceptance for that cycle.
  - REQ: if the PTW handshake completes in the same cycle, go to DRAIN; otherwise go to IDLE, drop the request, emit no response.
  - WALK: go to DRAIN.
  - DRAIN: no effect.
- A response never reaches the wrong requester, and a flushed walk never produces a response pulse.
- `ptw_req_is_store_o` = 0 and `ptw_req_is_instr_o` = 1 for ITLB requests.

## Timing
- Reset values:
  - FSM IDLE, `starve_cnt`=0, payload regs 0.
  - All valid/ready/err outputs 0, `busy_o`=0.
- Accept cycle N → `ptw_req_valid_o` high at N+1.
- `ptw_resp_valid_i` at cycle M → `*_resp_valid_o` pulses at M+1; the FSM is in IDLE at M+1 and may accept a new request in that same cycle.
- Minimum turnaround is 3 cycles per walk: accept, REQ with ready, response (with the PTW responding in the cycle after ready).
- Payload outputs are stable while `ptw_req_valid_o`=1. Valid is never withdrawn without a handshake, except on flush.
- `ptw_resp_valid_i` outside WALK/DRAIN is ignored.
- Reset mid-walk forces IDLE next cycle, regardless of `flush_i` or PTW state.

## Structure
- Shared package (alongside the cva6 config package): `ptw_arb_state_e` {IDLE, REQ, WALK, DRAIN}, `ptw_src_e` {SRC_ITLB, SRC_DTLB}, and the `ptw_arb_req_t` struct {vpn, v, is_store, src}.
- `VPN_W` is derived from the sv39 constants in that package.
- One sub-module: `ptw_rr_grant`, the grant logic plus the starvation counter.
- FSM and payload/response registers stay in the top module.

## Test plan
- Single DTLB miss, vpn=0x1234567, store=1, PTW ready immediately, response err=0 three cycles later. Expect `ptw_req_vpn_o`=0x1234567, `is_store`=1, one `dtlb_resp_valid_o` pulse, `itlb_resp_valid_o` never high.
- Both requesters continuously valid, PTW with 2-cycle latency, STARVE_LIMIT=4. Expect grant order D,D,D,D,I,D,D,D,D,I.
- Flush in REQ with `ptw_req_ready_i`=0. Expect IDLE next cycle, no response pulse, and a re-issued ITLB request accepted the cycle after.
- Flush during WALK, PTW responds err=1 five cycles later. Expect no `*_resp_valid_o`, `busy_o` low the cycle after the response, and no acceptance before then.
- ITLB miss with `HYP_EXT`=1, `itlb_req_v_i`=1, PTW error. Expect `ptw_req_v_o`=1, `is_instr`=1, `itlb_resp_err_o`=1 with its valid.
- `rst_i` asserted in WALK with DTLB still valid. Expect all outputs 0 next cycle, `starve_cnt`=0, and a later stray `ptw_resp_valid_i` ignored.

Source files
------------

// File: rtl/mmu_ptw_arbiter_pkg.sv
// Shared types for the MMU page-table-walker arbiter.
// Holds the sv39 VPN constants, the arbiter FSM states, the requester
// source encoding and the latched walk-request payload.
package mmu_ptw_arbiter_pkg;

    localparam int unsigned SV39_LEVELS    = 3;
    localparam int unsigned SV39_VPN_SEG_W = 9;
    localparam int unsigned SV39_VPN_W     = SV39_LEVELS * SV39_VPN_SEG_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WALK,
        DRAIN
    } ptw_arb_state_e;

    // DTLB encodes as 0 so a cleared payload never reads as an instruction walk.
    typedef enum logic {
        SRC_ITLB = 1'b1,
        SRC_DTLB = 1'b0
    } ptw_src_e;

    typedef struct packed {
        logic [SV39_VPN_W-1:0] vpn;
        logic                  v;
        logic                  is_store;
        ptw_src_e              src;
    } ptw_arb_req_t;

endpackage

// File: rtl/ptw_rr_grant.sv
// Grant selection between ITLB and DTLB miss requests with a starvation
// counter that forces an ITLB grant after STARVE_LIMIT consecutive DTLB wins.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  grant allowed this cycle (arbiter idle, no flush)
//   itlb_valid          ITLB miss pending
//   dtlb_valid          DTLB miss pending
//   grant               a request is granted this cycle (combinational)
//   grant_src           which requester is granted (combinational)
module ptw_rr_grant
    import mmu_ptw_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     itlb_valid,
    input  logic     dtlb_valid,
    output logic     grant,
    output ptw_src_e grant_src
);

    localparam int unsigned    CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             itlb_turn;

    // DTLB wins ties unless the ITLB has waited out the starvation limit.
    always_comb begin
        itlb_turn = itlb_valid && (!dtlb_valid || (starve_cnt == LIMIT));
        grant     = en && (itlb_valid || dtlb_valid);
        grant_src = itlb_turn ? SRC_ITLB : SRC_DTLB;
    end

    // Counts DTLB grants that bypassed a waiting ITLB; flush does not touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (!itlb_turn && itlb_valid) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mmu_ptw_arbiter.sv
// Shares the single page-table walker between ITLB and DTLB miss paths.
// One walk is outstanding at a time; the completion is routed back to the
// requester that issued it. Flush aborts queued or in-flight walks, and an
// aborted walk's completion is swallowed in DRAIN.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   flush_i                            abort pending / in-flight walk
//   itlb_req_*                         ITLB miss request, ready is combinational
//   dtlb_req_*                         DTLB miss request, ready is combinational
//   itlb_resp_*, dtlb_resp_*           registered one-cycle completion pulses
//   ptw_req_*                          request handshake and payload to the PTW
//   ptw_resp_valid_i, ptw_resp_err_i   walk completion from the PTW
//   busy_o                             arbiter not idle
module mmu_ptw_arbiter
    import mmu_ptw_arbiter_pkg::*;
#(
    parameter int unsigned VPN_W        = SV39_VPN_W,
    parameter int unsigned HYP_EXT      = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             itlb_req_valid_i,
    input  logic [VPN_W-1:0] itlb_req_vpn_i,
    input  logic             itlb_req_v_i,
    output logic             itlb_req_ready_o,
    input  logic             dtlb_req_valid_i,
    input  logic [VPN_W-1:0] dtlb_req_vpn_i,
    input  logic             dtlb_req_v_i,
    input  logic             dtlb_req_is_store_i,
    output logic             dtlb_req_ready_o,
    output logic             itlb_resp_valid_o,
    output logic             itlb_resp_err_o,
    output logic             dtlb_resp_valid_o,
    output logic             dtlb_resp_err_o,
    output logic             ptw_req_valid_o,
    input  logic             ptw_req_ready_i,
    output logic [VPN_W-1:0] ptw_req_vpn_o,
    output logic             ptw_req_is_instr_o,
    output logic             ptw_req_is_store_o,
    output logic             ptw_req_v_o,
    input  logic             ptw_resp_valid_i,
    input  logic             ptw_resp_err_i,
    output logic             busy_o
);

    ptw_arb_state_e state;
    ptw_arb_state_e state_next;
    ptw_arb_req_t   payload;
    logic           grant_en;
    logic           grant;
    ptw_src_e       grant_src;
    logic           resp_fire;

    // Reset also gates acceptance so nothing is handed out while it is held.
    assign grant_en = (state == IDLE) && !flush_i && !rst_i;

    ptw_rr_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk       (clk_i),
        .rst       (rst_i),
        .en        (grant_en),
        .itlb_valid(itlb_req_valid_i),
        .dtlb_valid(dtlb_req_valid_i),
        .grant     (grant),
        .grant_src (grant_src)
    );

    assign itlb_req_ready_o = grant && (grant_src == SRC_ITLB);
    assign dtlb_req_ready_o = grant && (grant_src == SRC_DTLB);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A completion landing together with a flush in WALK
    // is dropped outright rather than waiting in DRAIN for a second one.
    always_comb begin
        state_next = state;
        resp_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) state_next = REQ;
            end
            REQ: begin
                if (flush_i) begin
                    state_next = ptw_req_ready_i ? DRAIN : IDLE;
                end else if (ptw_req_ready_i) begin
                    state_next = WALK;
                end
            end
            WALK: begin
                if (ptw_resp_valid_i) begin
                    state_next = IDLE;
                    resp_fire  = !flush_i;
                end else if (flush_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (ptw_resp_valid_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload captured on grant and held stable through REQ/WALK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            payload <= '0;
        end else if (grant) begin
            if (grant_src == SRC_ITLB) begin
                payload <= '{vpn:      SV39_VPN_W'(itlb_req_vpn_i),
                             v:        (HYP_EXT != 0) && itlb_req_v_i,
                             is_store: 1'b0,
                             src:      SRC_ITLB};
            end else begin
                payload <= '{vpn:      SV39_VPN_W'(dtlb_req_vpn_i),
                             v:        (HYP_EXT != 0) && dtlb_req_v_i,
                             is_store: dtlb_req_is_store_i,
                             src:      SRC_DTLB};
            end
        end
    end

    // Completion pulses steered by the latched source.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            itlb_resp_valid_o <= 1'b0;
            itlb_resp_err_o   <= 1'b0;
            dtlb_resp_valid_o <= 1'b0;
            dtlb_resp_err_o   <= 1'b0;
        end else begin
            itlb_resp_valid_o <= resp_fire && (payload.src == SRC_ITLB);
            itlb_resp_err_o   <= resp_fire && (payload.src == SRC_ITLB) && ptw_resp_err_i;
            dtlb_resp_valid_o <= resp_fire && (payload.src == SRC_DTLB);
            dtlb_resp_err_o   <= resp_fire && (payload.src == SRC_DTLB) && ptw_resp_err_i;
        end
    end

    assign ptw_req_valid_o    = (state == REQ);
    assign ptw_req_vpn_o      = VPN_W'(payload.vpn);
    assign ptw_req_is_instr_o = (payload.src == SRC_ITLB);
    assign ptw_req_is_store_o = payload.is_store;
    assign ptw_req_v_o        = (HYP_EXT != 0) ? payload.v : 1'b0;
    assign busy_o             = (state != IDLE);

endmodule

// File: tb/tb_mmu_ptw_arbiter.sv
// Self-checking bench for mmu_ptw_arbiter: scenario tasks with a response
// scoreboard (expected completions queued at grant, popped at the pulse).
module tb_mmu_ptw_arbiter;

    localparam int unsigned VPN_W = 27;
    localparam logic [VPN_W-1:0] IVPN = 27'h2AAAAAA;
    localparam logic [VPN_W-1:0] DVPN = 27'h5555555;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             itlb_req_valid_i = 1'b0;
    logic [VPN_W-1:0] itlb_req_vpn_i = '0;
    logic             itlb_req_v_i = 1'b0;
    logic             itlb_req_ready_o;
    logic             dtlb_req_valid_i = 1'b0;
    logic [VPN_W-1:0] dtlb_req_vpn_i = '0;
    logic             dtlb_req_v_i = 1'b0;
    logic             dtlb_req_is_store_i = 1'b0;
    logic             dtlb_req_ready_o;
    logic             itlb_resp_valid_o;
    logic             itlb_resp_err_o;
    logic             dtlb_resp_valid_o;
    logic             dtlb_resp_err_o;
    logic             ptw_req_valid_o;
    logic             ptw_req_ready_i = 1'b0;
    logic [VPN_W-1:0] ptw_req_vpn_o;
    logic             ptw_req_is_instr_o;
    logic             ptw_req_is_store_o;
    logic             ptw_req_v_o;
    logic             ptw_resp_valid_i = 1'b0;
    logic             ptw_resp_err_i = 1'b0;
    logic             busy_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic itlb;
        logic err;
    } exp_t;

    typedef struct packed {
        logic             to;
        logic             gi;
        logic             gd;
        logic             rq;
        logic [VPN_W-1:0] vpn;
        logic             instr;
        logic             store;
        logic             hv;
        logic             riv;
        logic             rdv;
        logic             rerr;
    } obs_t;

    exp_t exp_q[$];

    mmu_ptw_arbiter #(
        .VPN_W       (VPN_W),
        .HYP_EXT     (1),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .itlb_req_valid_i   (itlb_req_valid_i),
        .itlb_req_vpn_i     (itlb_req_vpn_i),
        .itlb_req_v_i       (itlb_req_v_i),
        .itlb_req_ready_o   (itlb_req_ready_o),
        .dtlb_req_valid_i   (dtlb_req_valid_i),
        .dtlb_req_vpn_i     (dtlb_req_vpn_i),
        .dtlb_req_v_i       (dtlb_req_v_i),
        .dtlb_req_is_store_i(dtlb_req_is_store_i),
        .dtlb_req_ready_o   (dtlb_req_ready_o),
        .itlb_resp_valid_o  (itlb_resp_valid_o),
        .itlb_resp_err_o    (itlb_resp_err_o),
        .dtlb_resp_valid_o  (dtlb_resp_valid_o),
        .dtlb_resp_err_o    (dtlb_resp_err_o),
        .ptw_req_valid_o    (ptw_req_valid_o),
        .ptw_req_ready_i    (ptw_req_ready_i),
        .ptw_req_vpn_o      (ptw_req_vpn_o),
        .ptw_req_is_instr_o (ptw_req_is_instr_o),
        .ptw_req_is_store_o (ptw_req_is_store_o),
        .ptw_req_v_o        (ptw_req_v_o),
        .ptw_resp_valid_i   (ptw_resp_valid_i),
        .ptw_resp_err_i     (ptw_resp_err_i),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk_i);
    endtask

    // Runs one walk with whatever requests are currently driven: waits for a
    // grant, handshakes in REQ, answers after lat WALK cycles, and reports
    // what was seen. Ends in the cycle after the PTW response.
    task automatic do_walk(input logic err, input int lat, output obs_t o);
        o = '0;
        o.to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (itlb_req_ready_o || dtlb_req_ready_o) begin
                o.gi = itlb_req_ready_o;
                o.gd = dtlb_req_ready_o;
                o.to = 1'b0;
                break;
            end
            step();
            #1;
        end
        if (o.to) return;
        step();
        ptw_req_ready_i = 1'b1;
        #1;
        o.rq    = ptw_req_valid_o;
        o.vpn   = ptw_req_vpn_o;
        o.instr = ptw_req_is_instr_o;
        o.store = ptw_req_is_store_o;
        o.hv    = ptw_req_v_o;
        step();
        ptw_req_ready_i = 1'b0;
        repeat (lat - 1) step();
        ptw_resp_valid_i = 1'b1;
        ptw_resp_err_i   = err;
        step();
        ptw_resp_valid_i = 1'b0;
        ptw_resp_err_i   = 1'b0;
        #1;
        o.riv  = itlb_resp_valid_o;
        o.rdv  = dtlb_resp_valid_o;
        o.rerr = itlb_resp_err_o | dtlb_resp_err_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ptw_req_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_fsm: busy=%b req_valid=%b required 0/0", busy_o, ptw_req_valid_o);
        end
        checks++;
        if ({itlb_resp_valid_o, itlb_resp_err_o, dtlb_resp_valid_o, dtlb_resp_err_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_resp: got %b required 0000",
                     {itlb_resp_valid_o, itlb_resp_err_o, dtlb_resp_valid_o, dtlb_resp_err_o});
        end
        checks++;
        if (ptw_req_vpn_o !== '0 || {ptw_req_is_instr_o, ptw_req_is_store_o, ptw_req_v_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_payload: vpn=%h flags=%b required 0/000", ptw_req_vpn_o,
                     {ptw_req_is_instr_o, ptw_req_is_store_o, ptw_req_v_o});
        end
        checks++;
        if ({itlb_req_ready_o, dtlb_req_ready_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: got %b required 00", {itlb_req_ready_o, dtlb_req_ready_o});
        end
    endtask

    task automatic test_single_dtlb();
        logic i_seen;
        exp_t e;
        i_seen = 1'b0;
        step();
        dtlb_req_valid_i    = 1'b1;
        dtlb_req_vpn_i      = 27'h1234567;
        dtlb_req_is_store_i = 1'b1;
        dtlb_req_v_i        = 1'b0;
        #1;
        checks++;
        if ({itlb_req_ready_o, dtlb_req_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL single_accept: ready i/d=%b required 01", {itlb_req_ready_o, dtlb_req_ready_o});
        end
        exp_q.push_back('{itlb: 1'b0, err: 1'b0});
        step();
        dtlb_req_valid_i    = 1'b0;
        dtlb_req_is_store_i = 1'b0;
        ptw_req_ready_i     = 1'b1;
        #1;
        checks++;
        if (ptw_req_valid_o !== 1'b1 || ptw_req_vpn_o !== 27'h1234567) begin
            failures++;
            $display("FAIL single_req: valid=%b vpn=%h required 1/1234567", ptw_req_valid_o, ptw_req_vpn_o);
        end
        checks++;
        if ({ptw_req_is_store_o, ptw_req_is_instr_o, ptw_req_v_o} !== 3'b100) begin
            failures++;
            $display("FAIL single_flags: store/instr/v=%b required 100",
                     {ptw_req_is_store_o, ptw_req_is_instr_o, ptw_req_v_o});
        end
        step();
        ptw_req_ready_i = 1'b0;
        #1;
        i_seen |= itlb_resp_valid_o;
        step();
        #1;
        i_seen |= itlb_resp_valid_o;
        step();
        ptw_resp_valid_i = 1'b1;
        ptw_resp_err_i   = 1'b0;
        #1;
        i_seen |= itlb_resp_valid_o;
        step();
        ptw_resp_valid_i = 1'b0;
        #1;
        i_seen |= itlb_resp_valid_o;
        e = exp_q.pop_front();
        checks++;
        if (dtlb_resp_valid_o !== ~e.itlb || dtlb_resp_err_o !== e.err) begin
            failures++;
            $display("FAIL single_resp: dvalid=%b derr=%b required %b/%b",
                     dtlb_resp_valid_o, dtlb_resp_err_o, ~e.itlb, e.err);
        end
        step();
        #1;
        i_seen |= itlb_resp_valid_o;
        checks++;
        if (dtlb_resp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: dvalid=%b second cycle required 0", dtlb_resp_valid_o);
        end
        checks++;
        if (i_seen !== 1'b0) begin
            failures++;
            $display("FAIL single_no_itlb: itlb_resp seen=%b required 0", i_seen);
        end
    endtask

    task automatic test_starvation();
        logic exp_grant[$];
        logic gi;
        obs_t o;
        exp_t e;
        exp_grant = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        step();
        itlb_req_valid_i = 1'b1;
        itlb_req_vpn_i   = IVPN;
        itlb_req_v_i     = 1'b0;
        dtlb_req_valid_i = 1'b1;
        dtlb_req_vpn_i   = DVPN;
        #1;
        for (int n = 0; n < 10; n++) begin
            gi = exp_grant.pop_front();
            exp_q.push_back('{itlb: gi, err: 1'(n % 2)});
            do_walk(1'(n % 2), 2, o);
            e = exp_q.pop_front();
            checks++;
            if (o.to || o.gi !== gi || o.gd !== ~gi) begin
                failures++;
                $display("FAIL starve_grant[%0d]: to=%b i/d=%b%b required i=%b", n, o.to, o.gi, o.gd, gi);
            end
            checks++;
            if (o.rq !== 1'b1 || o.vpn !== (gi ? IVPN : DVPN) || o.instr !== gi) begin
                failures++;
                $display("FAIL starve_payload[%0d]: valid=%b vpn=%h instr=%b required 1/%h/%b",
                         n, o.rq, o.vpn, o.instr, gi ? IVPN : DVPN, gi);
            end
            checks++;
            if (o.riv !== e.itlb || o.rdv !== ~e.itlb || o.rerr !== e.err) begin
                failures++;
                $display("FAIL starve_resp[%0d]: i/d/err=%b%b%b required %b%b%b",
                         n, o.riv, o.rdv, o.rerr, e.itlb, ~e.itlb, e.err);
            end
        end
        itlb_req_valid_i = 1'b0;
        dtlb_req_valid_i = 1'b0;
    endtask

    task automatic test_flush_req();
        obs_t o;
        exp_t e;
        step();
        itlb_req_valid_i = 1'b1;
        itlb_req_vpn_i   = 27'h0012345;
        itlb_req_v_i     = 1'b0;
        #1;
        checks++;
        if (itlb_req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flushreq_accept: itlb_ready=%b required 1", itlb_req_ready_o);
        end
        step();
        flush_i         = 1'b1;
        ptw_req_ready_i = 1'b0;
        #1;
        checks++;
        if (ptw_req_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL flushreq_inreq: req_valid=%b required 1", ptw_req_valid_o);
        end
        step();
        flush_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ptw_req_valid_o !== 1'b0 || itlb_resp_valid_o !== 1'b0 || dtlb_resp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flushreq_idle: busy=%b req=%b resp i/d=%b%b required 0/0/00",
                     busy_o, ptw_req_valid_o, itlb_resp_valid_o, dtlb_resp_valid_o);
        end
        exp_q.push_back('{itlb: 1'b1, err: 1'b0});
        do_walk(1'b0, 1, o);
        itlb_req_valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (o.to || o.gi !== 1'b1 || o.vpn !== 27'h0012345) begin
            failures++;
            $display("FAIL flushreq_reissue: to=%b gi=%b vpn=%h required 0/1/0012345", o.to, o.gi, o.vpn);
        end
        checks++;
        if (o.riv !== e.itlb || o.rdv !== 1'b0 || o.rerr !== e.err) begin
            failures++;
            $display("FAIL flushreq_resp: i/d/err=%b%b%b required %b0%b", o.riv, o.rdv, o.rerr, e.itlb, e.err);
        end
    endtask

    task automatic test_flush_walk();
        logic bad;
        obs_t o;
        exp_t e;
        bad = 1'b0;
        step();
        dtlb_req_valid_i    = 1'b1;
        dtlb_req_vpn_i      = 27'h0777777;
        dtlb_req_is_store_i = 1'b0;
        flush_i             = 1'b1;
        #1;
        checks++;
        if (dtlb_req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_block: dtlb_ready=%b required 0", dtlb_req_ready_o);
        end
        step();
        flush_i = 1'b0;
        #1;
        checks++;
        if (dtlb_req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_release: dtlb_ready=%b required 1", dtlb_req_ready_o);
        end
        step();
        ptw_req_ready_i = 1'b1;
        step();
        ptw_req_ready_i = 1'b0;
        flush_i         = 1'b1;
        step();
        flush_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) step();
            if (k == 5) begin
                ptw_resp_valid_i = 1'b1;
                ptw_resp_err_i   = 1'b1;
            end
            #1;
            bad |= dtlb_req_ready_o | ~busy_o | itlb_resp_valid_o | dtlb_resp_valid_o;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL flushwalk_drain: accept/idle/resp seen=%b required 0", bad);
        end
        step();
        ptw_resp_valid_i = 1'b0;
        ptw_resp_err_i   = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || itlb_resp_valid_o !== 1'b0 || dtlb_resp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flushwalk_after: busy=%b resp i/d=%b%b required 0/00",
                     busy_o, itlb_resp_valid_o, dtlb_resp_valid_o);
        end
        exp_q.push_back('{itlb: 1'b0, err: 1'b0});
        do_walk(1'b0, 1, o);
        dtlb_req_valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (o.to || o.gd !== 1'b1 || o.rdv !== ~e.itlb || o.riv !== 1'b0 || o.rerr !== e.err) begin
            failures++;
            $display("FAIL flushwalk_next: to=%b gd=%b i/d/err=%b%b%b required 0/1/01%b",
                     o.to, o.gd, o.riv, o.rdv, o.rerr, e.err);
        end
    endtask

    task automatic test_hyp_itlb();
        obs_t o;
        exp_t e;
        step();
        itlb_req_valid_i = 1'b1;
        itlb_req_vpn_i   = 27'h0ABCDEF;
        itlb_req_v_i     = 1'b1;
        #1;
        exp_q.push_back('{itlb: 1'b1, err: 1'b1});
        do_walk(1'b1, 1, o);
        itlb_req_valid_i = 1'b0;
        itlb_req_v_i     = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (o.to || o.gi !== 1'b1 || o.vpn !== 27'h0ABCDEF) begin
            failures++;
            $display("FAIL hyp_grant: to=%b gi=%b vpn=%h required 0/1/0abcdef", o.to, o.gi, o.vpn);
        end
        checks++;
        if ({o.hv, o.instr, o.store} !== 3'b110) begin
            failures++;
            $display("FAIL hyp_flags: v/instr/store=%b required 110", {o.hv, o.instr, o.store});
        end
        checks++;
        if (o.riv !== e.itlb || o.rdv !== 1'b0 || o.rerr !== e.err) begin
            failures++;
            $display("FAIL hyp_resp: i/d/err=%b%b%b required %b0%b", o.riv, o.rdv, o.rerr, e.itlb, e.err);
        end
    endtask

    task automatic test_reset_mid_walk();
        obs_t o;
        logic exp_grant[$];
        logic gi;
        step();
        itlb_req_valid_i = 1'b1;
        itlb_req_vpn_i   = IVPN;
        dtlb_req_valid_i = 1'b1;
        dtlb_req_vpn_i   = DVPN;
        #1;
        for (int n = 0; n < 3; n++) begin
            do_walk(1'b0, 1, o);
            checks++;
            if (o.to || o.gd !== 1'b1) begin
                failures++;
                $display("FAIL rstwalk_pre[%0d]: to=%b gd=%b required 0/1", n, o.to, o.gd);
            end
        end
        checks++;
        if (dtlb_req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rstwalk_fourth: dtlb_ready=%b required 1", dtlb_req_ready_o);
        end
        step();
        ptw_req_ready_i = 1'b1;
        step();
        ptw_req_ready_i = 1'b0;
        rst_i           = 1'b1;
        step();
        #1;
        checks++;
        if ({itlb_req_ready_o, dtlb_req_ready_o, ptw_req_valid_o, busy_o,
             itlb_resp_valid_o, itlb_resp_err_o, dtlb_resp_valid_o, dtlb_resp_err_o,
             ptw_req_is_instr_o, ptw_req_is_store_o, ptw_req_v_o} !== 11'b0 || ptw_req_vpn_o !== '0) begin
            failures++;
            $display("FAIL rstwalk_outputs: rdy=%b%b req=%b busy=%b resp=%b%b%b%b flags=%b%b%b vpn=%h required all 0",
                     itlb_req_ready_o, dtlb_req_ready_o, ptw_req_valid_o, busy_o,
                     itlb_resp_valid_o, itlb_resp_err_o, dtlb_resp_valid_o, dtlb_resp_err_o,
                     ptw_req_is_instr_o, ptw_req_is_store_o, ptw_req_v_o, ptw_req_vpn_o);
        end
        rst_i            = 1'b0;
        itlb_req_valid_i = 1'b0;
        dtlb_req_valid_i = 1'b0;
        ptw_resp_valid_i = 1'b1;
        ptw_resp_err_i   = 1'b1;
        step();
        ptw_resp_valid_i = 1'b0;
        ptw_resp_err_i   = 1'b0;
        #1;
        checks++;
        if ({itlb_resp_valid_o, dtlb_resp_valid_o, busy_o} !== 3'b000) begin
            failures++;
            $display("FAIL rstwalk_stray: resp i/d=%b%b busy=%b required 000",
                     itlb_resp_valid_o, dtlb_resp_valid_o, busy_o);
        end
        // Counter must restart from zero: four DTLB wins before the ITLB.
        exp_grant = '{0, 0, 0, 0, 1};
        itlb_req_valid_i = 1'b1;
        dtlb_req_valid_i = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            gi = exp_grant.pop_front();
            do_walk(1'b0, 1, o);
            checks++;
            if (o.to || o.gi !== gi || o.riv !== gi || o.rdv !== ~gi) begin
                failures++;
                $display("FAIL rstwalk_order[%0d]: to=%b gi=%b resp i/d=%b%b required gi=%b", n, o.to, o.gi, o.riv, o.rdv, gi);
            end
        end
        itlb_req_valid_i = 1'b0;
        dtlb_req_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_dtlb();
        test_starvation();
        test_flush_req();
        test_flush_walk();
        test_hyp_itlb();
        test_reset_mid_walk();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
